// File: rtl/store_aligner_pkg.sv
// Shared encodings and lane-mask helpers for the store alignment path.
package store_aligner_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1
  } state_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  function automatic logic [3:0] base_mask(size_e size);
    unique case (size)
      SZ_BYTE: base_mask = MASK_BYTE;
      SZ_HALF: base_mask = MASK_HALF;
      SZ_WORD: base_mask = MASK_WORD;
      default: base_mask = MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/store_aligner_if.sv
// Core-side store request and memory-side write beat bundle.
interface store_aligner_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_we;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_we, done, err
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_we, done, err
  );
endinterface

// File: rtl/store_aligner_lane_gen.sv
// Combinational byte-lane steering: write enables and shifted data for one beat.
module store_lane_gen
  import store_aligner_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic [31:0] data,
  input  logic        beat_sel,
  output logic [3:0]  we,
  output logic [31:0] wdata,
  output logic        split
);

  logic [7:0]  full8;
  logic [63:0] full64;

  // Shifting into a 64-bit window yields both beats' lanes without a 32-bit shift case.
  always_comb begin
    full8  = {4'b0000, base_mask(size)} << off;
    full64 = {32'h0, data} << {off, 3'b000};
    split  = |full8[7:4];
    we     = beat_sel ? full8[7:4]     : full8[3:0];
    wdata  = beat_sel ? full64[63:32]  : full64[31:0];
  end

endmodule

// File: rtl/store_aligner.sv
// Splits byte/half/word stores at any byte address into word-aligned write beats.
module store_aligner
  import store_aligner_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  store_aligner_if.slave  bus
);

  state_e            state_q, state_d;
  logic [1:0]        off_q, off_d;
  size_e             size_q, size_d;
  logic [31:0]       data_q, data_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [1:0]  lg_off;
  size_e       lg_size;
  logic [31:0] lg_data;
  logic        lg_beat;
  logic [3:0]  lg_we;
  logic [31:0] lg_wdata;
  logic        lg_split;

  // In IDLE the generator looks at the incoming request to preload beat 0;
  // in BEAT0 it looks at the latched request to preload beat 1.
  always_comb begin
    if (state_q == ST_IDLE) begin
      lg_off  = bus.req_addr[1:0];
      lg_size = size_e'(bus.req_size);
      lg_data = bus.req_data;
    end else begin
      lg_off  = off_q;
      lg_size = size_q;
      lg_data = data_q;
    end
    lg_beat = (state_q == ST_BEAT0);
  end

  store_lane_gen u_lane_gen (
    .off      (lg_off),
    .size     (lg_size),
    .data     (lg_data),
    .beat_sel (lg_beat),
    .we       (lg_we),
    .wdata    (lg_wdata),
    .split    (lg_split)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    data_d      = data_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          off_d  = bus.req_addr[1:0];
          size_d = size_e'(bus.req_size);
          data_d = bus.req_data;
          if (size_e'(bus.req_size) == SZ_RSVD) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d     = ST_BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = lg_wdata;
            mem_we_d    = lg_we;
          end
        end
      end
      ST_BEAT0: begin
        if (bus.mem_ready) begin
          if (lg_split) begin
            state_d     = ST_BEAT1;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_wdata_d = lg_wdata;
            mem_we_d    = lg_we;
          end else begin
            state_d     = ST_IDLE;
            mem_valid_d = 1'b0;
            mem_wdata_d = 32'h0;
            mem_we_d    = 4'b0000;
            done_d      = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        if (bus.mem_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          mem_wdata_d = 32'h0;
          mem_we_d    = 4'b0000;
          done_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      data_q      <= 32'h0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      data_q      <= data_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE) && rst;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_store_aligner.sv
// Scoreboard bench for store_aligner: expected beats/completions queued at drive time.
module tb_store_aligner;

  localparam int unsigned AddrW = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_aligner_if #(.ADDR_W(AddrW)) bus ();

  store_aligner #(.ADDR_W(AddrW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t beat_q[$];
  logic  done_exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: place each request byte j into lane off+j of an 8-lane window.
  task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int          nb;
    int          off;
    int          j;
    logic [7:0]  en;
    logic [63:0] lanes;
    beat_t       b;
    if (sz == 2'b11) begin
      done_exp_q.push_back(1'b1);
      return;
    end
    nb    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off   = int'(a[1:0]);
    en    = '0;
    lanes = '0;
    for (int i = 0; i < 8; i++) begin
      j = i - off;
      if (j >= 0 && j < nb) en[i] = 1'b1;
      if (j >= 0 && j < 4) lanes[8*i +: 8] = d[8*j +: 8];
    end
    b.addr  = {a[31:2], 2'b00};
    b.we    = en[3:0];
    b.wdata = lanes[31:0];
    beat_q.push_back(b);
    if (en[7:4] != 4'b0000) begin
      b.addr  = {a[31:2], 2'b00} + 32'd4;
      b.we    = en[7:4];
      b.wdata = lanes[63:32];
      beat_q.push_back(b);
    end
    done_exp_q.push_back(1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single edge; returns #1 after the accepting edge.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    push_req(a, d, sz);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = sz;
    check_val("req_ready_before_accept", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_data  = $urandom;
    bus.req_size  = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!bus.done && lat < budget) begin
      step();
      lat++;
    end
    if (!bus.done) check_val("done_timeout", bus.done, 1);
  endtask

  // Monitor: pop/compare on each handshake, check hold during stalls and idle zeros.
  logic        prev_stall = 1'b0;
  logic [31:0] p_addr;
  logic [3:0]  p_we;
  logic [31:0] p_wdata;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", bus.mem_valid, 1);
        check_val("hold_addr", bus.mem_addr, p_addr);
        check_val("hold_we", bus.mem_we, p_we);
        check_val("hold_wdata", bus.mem_wdata, p_wdata);
      end
      if (bus.mem_valid && bus.mem_ready) begin
        if (beat_q.size() == 0) begin
          check_val("unexpected_beat", bus.mem_valid, 0);
        end else begin
          check_val("beat_addr", bus.mem_addr, beat_q[0].addr);
          check_val("beat_we", bus.mem_we, beat_q[0].we);
          check_val("beat_wdata", bus.mem_wdata, beat_q[0].wdata);
          void'(beat_q.pop_front());
        end
      end else if (!bus.mem_valid) begin
        check_val("idle_we", bus.mem_we, 0);
        check_val("idle_wdata", bus.mem_wdata, 0);
      end
      if (bus.done) begin
        if (done_exp_q.size() == 0) begin
          check_val("unexpected_done", bus.done, 0);
        end else begin
          check_val("done_err", bus.err, done_exp_q[0]);
          void'(done_exp_q.pop_front());
        end
      end else begin
        check_val("err_without_done", bus.err, 0);
      end
      prev_stall <= bus.mem_valid && !bus.mem_ready;
      p_addr     <= bus.mem_addr;
      p_we       <= bus.mem_we;
      p_wdata    <= bus.mem_wdata;
    end
  end

  initial begin
    int lat;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = 2'b00;
    bus.mem_ready = 1'b1;
    step();
    step();
    check_val("rst_mem_valid", bus.mem_valid, 0);
    check_val("rst_mem_we", bus.mem_we, 0);
    check_val("rst_mem_addr", bus.mem_addr, 0);
    check_val("rst_mem_wdata", bus.mem_wdata, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_err", bus.err, 0);
    check_val("rst_req_ready", bus.req_ready, 0);
    rst = 1'b1;
    #1;
    check_val("idle_req_ready", bus.req_ready, 1);

    // Byte store at offset 2.
    do_req(32'h0000_1002, 32'h0000_00AB, 2'b00);
    check_val("byte_valid", bus.mem_valid, 1);
    check_val("byte_addr", bus.mem_addr, 32'h0000_1000);
    check_val("byte_we", bus.mem_we, 4'b0100);
    check_val("byte_wdata", bus.mem_wdata, 32'h00AB_0000);
    wait_done(20, lat);
    check_val("byte_latency", lat, 1);
    check_val("byte_err", bus.err, 0);

    // Back-to-back: accept the aligned word in the done cycle.
    check_val("b2b_req_ready", bus.req_ready, 1);
    do_req(32'h0000_2000, 32'hDEAD_BEEF, 2'b10);
    check_val("word_we", bus.mem_we, 4'b1111);
    wait_done(20, lat);
    check_val("word_latency", lat, 1);

    // Split word at offset 1.
    do_req(32'h0000_3001, 32'h1122_3344, 2'b10);
    check_val("split_b0_wdata", bus.mem_wdata, 32'h2233_4400);
    step();
    check_val("split_b1_addr", bus.mem_addr, 32'h0000_3004);
    check_val("split_b1_we", bus.mem_we, 4'b0001);
    check_val("split_b1_wdata", bus.mem_wdata, 32'h0000_0011);
    check_val("split_no_early_done", bus.done, 0);
    step();
    check_val("split_done", bus.done, 1);
    step();
    check_val("split_single_done", bus.done, 0);

    // Split half at 0x40FF with 3 stall cycles per beat.
    bus.mem_ready = 1'b0;
    do_req(32'h0000_40FF, 32'h0000_BEEF, 2'b01);
    check_val("bp_b0_addr", bus.mem_addr, 32'h0000_40FC);
    check_val("bp_b0_we", bus.mem_we, 4'b1000);
    for (int beat = 0; beat < 2; beat++) begin
      for (int s = 0; s < 3; s++) begin
        step();
        check_val("bp_req_ready", bus.req_ready, 0);
        check_val("bp_no_done", bus.done, 0);
      end
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      if (beat == 0) begin
        check_val("bp_b1_addr", bus.mem_addr, 32'h0000_4100);
        check_val("bp_b1_we", bus.mem_we, 4'b0001);
        check_val("bp_mid_no_done", bus.done, 0);
      end
    end
    check_val("bp_done", bus.done, 1);
    bus.mem_ready = 1'b1;
    step();

    // Reserved size: no beat, done+err next cycle.
    do_req(32'h0000_5003, 32'h1234_5678, 2'b11);
    check_val("rsvd_valid", bus.mem_valid, 0);
    check_val("rsvd_done", bus.done, 1);
    check_val("rsvd_err", bus.err, 1);
    step();
    check_val("rsvd_done_pulse", bus.done, 0);

    // Address wrap on the second beat.
    do_req(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'b10);
    step();
    check_val("wrap_b1_addr", bus.mem_addr, 32'h0000_0000);
    check_val("wrap_b1_we", bus.mem_we, 4'b0011);
    wait_done(20, lat);
    check_val("wrap_latency", lat, 1);
    step();

    // Reset while stalled in BEAT1.
    do_req(32'h0000_6002, 32'h5566_7788, 2'b10);
    step();
    bus.mem_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_val("midrst_valid", bus.mem_valid, 0);
    check_val("midrst_we", bus.mem_we, 0);
    check_val("midrst_done", bus.done, 0);
    check_val("midrst_pending_beats", beat_q.size(), 1);
    beat_q.delete();
    done_exp_q.delete();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    step();
    check_val("postrst_req_ready", bus.req_ready, 1);
    check_val("postrst_done", bus.done, 0);
    do_req(32'h0000_7000, 32'h0000_CAFE, 2'b01);
    wait_done(20, lat);
    check_val("postrst_latency", lat, 1);
    step();

    check_val("beats_drained", beat_q.size(), 0);
    check_val("dones_drained", done_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
